// File: rtl/dpy_scan_multi.sv
// Multiplexed seven-segment scan driver with PWM brightness, leading-zero
// suppression, per-digit blanking and a tear-free (frame-aligned) content update.
// Latency: sel_o/seg_o registered, one cycle after slot/digit state; accepted
//   content shows from the first slot of the following frame.
// Backpressure: upd_ready low while one update is pending; it clears at the frame boundary.
//
// Ports:
//   clock, reset_n          single clock, synchronous active-low reset
//   upd_valid/upd_ready     content handshake; upd_number (nibble per digit), upd_dp
//   blank_mask, lz_en,
//   bright                  live display controls, effective the next cycle
//   blink_mask              digits that blink (only with DPY_BLINK_EN defined)
//   sel_o, seg_o            one-hot digit select, segments {dp,g,f,e,d,c,b,a}
//
// Optional feature: define DPY_BLINK_EN to build the blink frame counter.

module dpy_scan_multi #(
  parameter int DIGIT_CNT    = 8,
  parameter int SCAN_DIV     = 4096,
  parameter int BRIGHT_WIDTH = 3,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [4*DIGIT_CNT-1:0]    upd_number,
  input  logic [DIGIT_CNT-1:0]      upd_dp,
  input  logic [DIGIT_CNT-1:0]      blank_mask,
  input  logic                      lz_en,
  input  logic [BRIGHT_WIDTH-1:0]   bright,
  input  logic [DIGIT_CNT-1:0]      blink_mask,
  output logic [DIGIT_CNT-1:0]      sel_o,
  output logic [7:0]                seg_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGIT_CNT > 1) ? $clog2(DIGIT_CNT) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGIT_CNT - 1);
  localparam logic [CW:0]   PWM_STEP  = (CW+1)'(SCAN_DIV >> BRIGHT_WIDTH);

  logic [CW-1:0]           slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*DIGIT_CNT-1:0]  act_num_q, act_num_d, pend_num_q, pend_num_d;
  logic [DIGIT_CNT-1:0]    act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                    pend_full_q, pend_full_d;
  logic [DIGIT_CNT-1:0]    sel_q, sel_d;
  logic [7:0]              seg_q, seg_d;

  logic                    slot_last, frame_end, accept;
  logic                    zero_run;
  logic [DIGIT_CNT-1:0]    lz_sup;
  logic [3:0]              nib;
  logic [CW:0]             bright_ext, pwm_lim;
  logic                    pwm_on;
  logic                    blink_phase, blink_dark;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign slot_last = (slot_cnt_q == SLOT_LAST);
  assign frame_end = slot_last && (idx_q == IDX_LAST);
  assign upd_ready = !pend_full_q;
  assign accept    = upd_valid && !pend_full_q;

  // Scan counters and the pending/active content pair. An accept can never
  // coincide with a commit: commit needs pend_full, accept needs it clear.
  always_comb begin
    slot_cnt_d  = slot_last ? '0 : slot_cnt_q + CW'(1);
    idx_d       = idx_q;
    if (slot_last) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    act_num_d   = act_num_q;
    act_dp_d    = act_dp_q;
    pend_num_d  = pend_num_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    if (accept) begin
      pend_num_d  = upd_number;
      pend_dp_d   = upd_dp;
      pend_full_d = 1'b1;
    end else if (frame_end && pend_full_q) begin
      act_num_d   = pend_num_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end
  end

  // A digit is suppressed when it and every digit above it hold zero;
  // digit 0 always shows so an all-zero value still reads "0".
  always_comb begin
    zero_run = 1'b1;
    lz_sup   = '0;
    for (int k = DIGIT_CNT - 1; k >= 0; k--) begin
      zero_run  = zero_run & (act_num_q[4*k +: 4] == 4'd0);
      lz_sup[k] = lz_en & zero_run & (k != 0);
    end
  end

  // Full code gives bright_ext+1 == 2^BRIGHT_WIDTH, so the limit equals SCAN_DIV.
  assign bright_ext = {{(CW + 1 - BRIGHT_WIDTH){1'b0}}, bright};
  assign pwm_lim    = (bright_ext + (CW+1)'(1)) * PWM_STEP;
  assign pwm_on     = ({1'b0, slot_cnt_q} < pwm_lim);

`ifdef DPY_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        frame_cnt_d   = frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_phase = blink_phase_q;
`else
  assign blink_phase = 1'b0;
`endif

  assign blink_dark = blink_phase & blink_mask[idx_q];
  assign nib        = act_num_q[{idx_q, 2'b00} +: 4];

  // Select stays asserted while the digit is dark; only segments go low.
  // A suppressed digit keeps its dp, a blanked/blinked/PWM-off one does not.
  always_comb begin
    sel_d        = '0;
    sel_d[idx_q] = 1'b1;
    seg_d        = {act_dp_q[idx_q], hex7(nib)};
    if (lz_sup[idx_q]) seg_d[6:0] = '0;
    if (blank_mask[idx_q] || blink_dark || !pwm_on) seg_d = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      slot_cnt_q  <= '0;
      idx_q       <= '0;
      act_num_q   <= '0;
      act_dp_q    <= '0;
      pend_num_q  <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
      sel_q       <= '0;
      seg_q       <= '0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      idx_q       <= idx_d;
      act_num_q   <= act_num_d;
      act_dp_q    <= act_dp_d;
      pend_num_q  <= pend_num_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
    end
  end

  assign sel_o = sel_q;
  assign seg_o = seg_q;

endmodule

// File: tb/tb_dpy_scan_multi.sv
module tb_dpy_scan_multi;

  localparam int DC = 8;
  localparam int SD = 16;
  localparam int BW = 2;
  localparam int BF = 2;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            upd_valid;
  logic            upd_ready;
  logic [4*DC-1:0] upd_number;
  logic [DC-1:0]   upd_dp;
  logic [DC-1:0]   blank_mask;
  logic            lz_en;
  logic [BW-1:0]   bright;
  logic [DC-1:0]   blink_mask;
  logic [DC-1:0]   sel_o;
  logic [7:0]      seg_o;

  int checks = 0;
  int errors = 0;
  int t = 0;
  logic [7:0] exp_seg [DC];
  logic [7:0] blink_d0;

  always #5 clock = ~clock;

  dpy_scan_multi #(
    .DIGIT_CNT(DC), .SCAN_DIV(SD), .BRIGHT_WIDTH(BW), .BLINK_FRAMES(BF)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_number(upd_number), .upd_dp(upd_dp),
    .blank_mask(blank_mask), .lz_en(lz_en), .bright(bright),
    .blink_mask(blink_mask), .sel_o(sel_o), .seg_o(seg_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0d got=0x%0h want=0x%0h", tag, t, got, want);
    end
  endtask

  // One clock edge; returns on the following falling edge, where the bench
  // both samples outputs and drives inputs for the next edge.
  task automatic tick();
    @(posedge clock);
    t++;
    @(negedge clock);
  endtask

  // Walks one full frame (8 digits x 16 cycles) checking every output cycle
  // against exp_seg. on_cyc = hand-computed lit cycles per slot. Optionally
  // offers an update mid-frame, then a rival value while the first is pending.
  task automatic run_frame(input int on_cyc, input int lit0_exp, input bit do_offer,
                           input logic [31:0] offer_num, input logic [7:0] offer_dp);
    int lit0 = 0;
    for (int i = 1; i <= DC*SD; i++) begin
      if (do_offer && i == 41) begin
        check("rdy_before_offer", 32'(upd_ready), 32'd1);
        upd_valid  = 1'b1;
        upd_number = offer_num;
        upd_dp     = offer_dp;
      end
      if (do_offer && i == 42) begin
        upd_number = 32'h0000_0055;
        upd_dp     = 8'hFF;
      end
      if (do_offer && i == 50) upd_valid = 1'b0;
      tick();
      begin
        int slot = (t - 1) % SD;
        int d    = ((t - 1) / SD) % DC;
        check("sel", 32'(sel_o), 32'(1 << d));
        check("seg", 32'(seg_o), (slot < on_cyc) ? 32'(exp_seg[d]) : 32'd0);
        if (d == 0 && seg_o != 8'h00) lit0++;
      end
      if (do_offer && (i == 41 || i == 127)) check("rdy_pending", 32'(upd_ready), 32'd0);
      if (do_offer && i == DC*SD)             check("rdy_after_commit", 32'(upd_ready), 32'd1);
    end
    check("lit_cycles_d0", 32'(lit0), 32'(lit0_exp));
  endtask

  initial begin
    reset_n = 1'b0; upd_valid = 1'b0; upd_number = '0; upd_dp = '0;
    blank_mask = '0; lz_en = 1'b0; bright = 2'd3; blink_mask = '0;

    tick();
    check("rst_sel", 32'(sel_o), 32'd0);
    check("rst_seg", 32'(seg_o), 32'd0);
    tick(); tick();
    check("rst_sel_hold", 32'(sel_o), 32'd0);
    reset_n = 1'b1;
    t = 0;
    check("post_rst_sel", 32'(sel_o), 32'd0);
    check("post_rst_rdy", 32'(upd_ready), 32'd1);

    // F1: idle, all zeros, no suppression
    exp_seg = '{8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
    run_frame(16, 16, 1'b0, 32'h0, 8'h0);
    // F2: leading zeros suppressed
    lz_en = 1'b1;
    exp_seg = '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(16, 16, 1'b0, 32'h0, 8'h0);
    // F3: offer 0x12AF mid-frame; display must not change yet
    run_frame(16, 16, 1'b1, 32'h0000_12AF, 8'h00);
    // F4: committed content F,A,2,1 then suppressed
    exp_seg = '{8'h71, 8'h77, 8'h5B, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(16, 16, 1'b0, 32'h0, 8'h0);
    // F5: bright=1 lights 8 of 16; F6: bright=0 lights 4 of 16
    bright = 2'd1;
    run_frame(8, 8, 1'b0, 32'h0, 8'h0);
    bright = 2'd0;
    run_frame(4, 4, 1'b1, 32'h8765_4321, 8'h04);
    // F7: digit 2 blanked, dp included
    bright = 2'd3; lz_en = 1'b0; blank_mask = 8'h04;
    exp_seg = '{8'h06, 8'h5B, 8'h00, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
    run_frame(16, 16, 1'b0, 32'h0, 8'h0);
    // F8: unblanked, digit 2 shows "3" with dp
    blank_mask = 8'h00;
    exp_seg = '{8'h06, 8'h5B, 8'hCF, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
    run_frame(16, 16, 1'b1, 32'h0000_0007, 8'h08);
    // F9-F10: suppressed digit 3 keeps its dp
    lz_en = 1'b1;
    exp_seg = '{8'h07, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(16, 16, 1'b0, 32'h0, 8'h0);
    run_frame(16, 16, 1'b0, 32'h0, 8'h0);
    // F11-F14: digit 0 blinks; phase flips every 2 frames from reset
    blink_mask = 8'h01;
`ifdef DPY_BLINK_EN
    blink_d0 = 8'h00;
`else
    blink_d0 = 8'h07;
`endif
    exp_seg[0] = blink_d0;
    run_frame(16, (blink_d0 != 0) ? 16 : 0, 1'b0, 32'h0, 8'h0);
    run_frame(16, (blink_d0 != 0) ? 16 : 0, 1'b0, 32'h0, 8'h0);
    exp_seg[0] = 8'h07;
    run_frame(16, 16, 1'b0, 32'h0, 8'h0);
    run_frame(16, 16, 1'b0, 32'h0, 8'h0);

    // Reset while an update is pending: it must be discarded
    blink_mask = 8'h00;
    upd_valid = 1'b1; upd_number = 32'h0000_000F; upd_dp = 8'h00;
    tick();
    upd_valid = 1'b0;
    check("rdy_pending_pre_rst", 32'(upd_ready), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    reset_n = 1'b0;
    tick();
    check("mid_rst_sel", 32'(sel_o), 32'd0);
    check("mid_rst_seg", 32'(seg_o), 32'd0);
    tick();
    reset_n = 1'b1;
    t = 0;
    check("rst2_sel", 32'(sel_o), 32'd0);
    check("rst2_rdy", 32'(upd_ready), 32'd1);
    exp_seg = '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(16, 16, 1'b0, 32'h0, 8'h0);
    run_frame(16, 16, 1'b0, 32'h0, 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
